uart_baud_gen_frac: RTL and testbench
=====================================

Name: uart_baud_gen_frac

Overview:
- Runtime-programmable fractional baud generator shared by the UART TX and RX paths.
- Produces an oversample tick (OVERSAMPLE per bit), a bit tick and a mid-bit tick from one counter chain.
- The average oversample period is div_int + div_frac/2^FRAC_W clocks, giving low error at high baud rates.
- resync lets the RX start-bit detector realign the bit phase.

Parameters:
- DIV_INT_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor and phase accumulator.
- OVERSAMPLE, 16: oversample ticks per bit; must be a power of 2 and at least 4.
- DEF_DIV_INT, 27: integer divisor loaded at reset (50 MHz, 115200 baud, 16x).
- DEF_DIV_FRAC, 2: fractional divisor loaded at reset.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: generator enable.
- div_int_i, input, DIV_INT_W: new integer divisor.
- div_frac_i, input, FRAC_W: new fractional divisor.
- div_load, input, 1: one-cycle strobe; captures div_int_i and div_frac_i into the shadow registers.
- resync, input, 1: restart bit phase from zero.
- os_tick, output, 1: one-clock pulse per oversample period.
- bit_tick, output, 1: one-clock pulse per bit (every OVERSAMPLE os_ticks).
- mid_tick, output, 1: one-clock pulse at bit centre.
- os_cnt, output, $clog2(OVERSAMPLE): current oversample index within the bit.

Behaviour:
- Reset (async, rst_n low):
  - Active and shadow divisors = DEF_DIV_INT / DEF_DIV_FRAC.
  - Clock counter, phase accumulator and os_cnt = 0.
  - os_tick, bit_tick and mid_tick = 0.
- Divisor register:
  - Effective div_int = max(div_int, 2); values 0 and 1 are clamped to 2.
  - div_load writes the shadow registers only.
  - Shadow copies to active at the first period start after the load, so no partial period ever mixes two divisors.
  - If en = 0, shadow copies to active on the next clock.
  - div_load and a period start in the same cycle: the new value is used for that period.
- Period start, defined as the first enabled cycle, the cycle after the terminal count, or after resync:
  - {carry, acc} <= acc + div_frac_active.
  - Period length L = div_int_active + carry.
  - Clock counter runs 0..L-1.
- os_tick:
  - Registered; high for exactly one clock in the cycle after the counter reaches L-1.
  - With en high from edge 0, the first os_tick is high in cycle L; thereafter one pulse every L cycles.
  - Example: div_frac = 8, FRAC_W = 4 gives periods 4,5,4,5,… for div_int = 4.
- os_cnt:
  - Increments modulo OVERSAMPLE on each os_tick, in the same edge on which os_tick is registered.
- bit_tick:
  - Asserted in the same cycle as os_tick when os_cnt wraps OVERSAMPLE-1 → 0.
- mid_tick:
  - Asserted in the same cycle as os_tick when os_cnt goes OVERSAMPLE/2-1 → OVERSAMPLE/2.
- en = 0:
  - Clock counter, accumulator and os_cnt cleared synchronously.
  - All ticks 0 from the next cycle.
  - Re-enable restarts phase exactly as after reset, but with the active divisor retained.
- resync (priority over en-driven counting):
  - Clears clock counter, accumulator and os_cnt; ticks are 0 in the next cycle.
  - The first os_tick after resync is L cycles after resync is sampled.
  - A tick coinciding with resync is suppressed.
  - Held resync keeps the block cleared.
- Ordering: simultaneous resync and div_load are both honoured; the load lands and the new divisor applies to the period resync starts.
- Outputs are glitch-free registers; there is no combinational path from any input to any output.

Test Plan:
- Reset release with defaults, en = 1:
  - os_tick periods follow the 27/27…/28 pattern with a carry every 8th period (acc + 2 wraps at 16).
  - 16 os_ticks = 434 clocks.
- div_int = 4, div_frac = 0, OVERSAMPLE = 16:
  - os_tick every 4 clocks; bit_tick every 64 clocks, coincident with the 16th os_tick.
  - mid_tick coincident with the 8th os_tick.
- div_int = 4, div_frac = 8:
  - Periods alternate 4,5.
  - bit_tick spacing is exactly 72 clocks.
  - os_cnt sequence is 0..15 wrapping.
- div_load of div_int = 10 issued 2 clocks into a 4-clock period:
  - The current period stays 4.
  - The next period is 10.
  - div_int = 1 loaded: period clamps to 2.
- resync asserted 1 clock before an expected bit_tick:
  - No bit_tick or os_tick in the following cycle.
  - os_cnt = 0.
  - Next os_tick L cycles later; bit_tick 16·L later (div_frac = 0).
- rst_n low mid-bit, plus en toggle:
  - All outputs 0 asynchronously; divisors revert to defaults.
  - en low for 5 cycles then high: first os_tick L cycles after re-enable, os_cnt restarted at 0.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: oversample, bit and mid-bit ticks from one counter chain.
// Ticks are registered; first os_tick lands L cycles after the period-start cycle.
module uart_baud_gen_frac #(
  parameter int DIV_INT_W    = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEF_DIV_INT  = 27,
  parameter int DEF_DIV_FRAC = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DIV_INT_W-1:0]          div_int_i,
  input  logic [FRAC_W-1:0]             div_frac_i,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_cnt
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int LEN_W = DIV_INT_W + 1;

  logic [DIV_INT_W-1:0] act_int_q, act_int_d, sh_int_q, sh_int_d;
  logic [FRAC_W-1:0]    act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic [FRAC_W-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d, len_q, len_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic                 run_q, run_d;
  logic                 os_tick_q, os_tick_d;
  logic                 bit_tick_q, bit_tick_d;
  logic                 mid_tick_q, mid_tick_d;

  logic [DIV_INT_W-1:0] nxt_int;
  logic [FRAC_W-1:0]    nxt_frac;
  logic [FRAC_W:0]      sum;
  logic [LEN_W-1:0]     base_len;

  always_comb begin
    // A load in the same cycle as a period start must win over the shadow copy.
    nxt_int    = div_load ? div_int_i  : sh_int_q;
    nxt_frac   = div_load ? div_frac_i : sh_frac_q;
    sh_int_d   = nxt_int;
    sh_frac_d  = nxt_frac;
    sum        = {1'b0, acc_q} + {1'b0, nxt_frac};
    base_len   = (nxt_int < DIV_INT_W'(2)) ? LEN_W'(2) : LEN_W'(nxt_int);

    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    os_cnt_d   = os_cnt_q;
    run_d      = run_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    if (!en || resync) begin
      acc_d    = '0;
      cnt_d    = '0;
      os_cnt_d = '0;
      run_d    = 1'b0;
      if (!en) begin
        act_int_d  = nxt_int;
        act_frac_d = nxt_frac;
      end
    end else if (!run_q) begin
      // Period start: latch divisor, step the phase accumulator, size this period.
      act_int_d  = nxt_int;
      act_frac_d = nxt_frac;
      acc_d      = sum[FRAC_W-1:0];
      len_d      = base_len + LEN_W'(sum[FRAC_W]);
      cnt_d      = LEN_W'(1);
      run_d      = 1'b1;
    end else if (cnt_q == len_q - LEN_W'(1)) begin
      cnt_d      = '0;
      run_d      = 1'b0;
      os_tick_d  = 1'b1;
      os_cnt_d   = os_cnt_q + OS_W'(1);
      bit_tick_d = (os_cnt_q == OS_W'(OVERSAMPLE - 1));
      mid_tick_d = (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
    end else begin
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int_q  <= DIV_INT_W'(DEF_DIV_INT);
      act_frac_q <= FRAC_W'(DEF_DIV_FRAC);
      sh_int_q   <= DIV_INT_W'(DEF_DIV_INT);
      sh_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      os_cnt_q   <= '0;
      run_q      <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      os_cnt_q   <= os_cnt_d;
      run_q      <= run_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign os_cnt   = os_cnt_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: tick timing predicted from divisor arithmetic.
module tb_uart_baud_gen_frac;

  localparam int FRAC_W = 4;
  localparam int OS     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div_int_i;
  logic [3:0]  div_frac_i;
  logic        div_load;
  logic        resync;
  logic        os_tick, bit_tick, mid_tick;
  logic [3:0]  os_cnt;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  uart_baud_gen_frac dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .div_int_i(div_int_i), .div_frac_i(div_frac_i),
    .div_load(div_load), .resync(resync),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .os_cnt(os_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Length of the k-th period (k from 1) after a phase restart.
  function automatic int model_len(input int di, input int df, input int k);
    int base;
    base = (di < 2) ? 2 : di;
    return base + (k * df) / (1 << FRAC_W) - ((k - 1) * df) / (1 << FRAC_W);
  endfunction

  task automatic wait_tick(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (os_tick !== 1'b1 && n < 2000);
    t = cyc;
    if (os_tick !== 1'b1) begin
      total++; bad++;
      $display("FAIL os_tick_timeout: no os_tick within %0d cycles, want one", n);
    end
  endtask

  task automatic load_div(input int di, input int df);
    div_int_i  = 16'(di);
    div_frac_i = 4'(df);
    div_load   = 1'b1;
    @(negedge clk);
    div_load   = 1'b0;
  endtask

  task automatic test_run(input int di, input int df, input int n, input bit do_load,
                          output int elapsed, output int bit_gap);
    int start, t, expt, first_bit;
    first_bit = -1; bit_gap = -1; t = 0;
    if (do_load) begin
      load_div(di, df);
      @(negedge clk);
    end
    en = 1'b1; start = cyc; expt = start;
    for (int k = 1; k <= n; k++) begin
      wait_tick(t);
      expt += model_len(di, df, k);
      total++;
      if (t !== expt) begin
        bad++; $display("FAIL tick_time di=%0d df=%0d k=%0d: got cycle %0d want %0d", di, df, k, t - start, expt - start);
      end
      total++;
      if (os_cnt !== 4'(k % OS)) begin
        bad++; $display("FAIL os_cnt di=%0d df=%0d k=%0d: got %0d want %0d", di, df, k, os_cnt, k % OS);
      end
      total++;
      if (bit_tick !== (k % OS == 0)) begin
        bad++; $display("FAIL bit_tick di=%0d df=%0d k=%0d: got %b want %b", di, df, k, bit_tick, (k % OS == 0));
      end
      total++;
      if (mid_tick !== (k % OS == OS / 2)) begin
        bad++; $display("FAIL mid_tick di=%0d df=%0d k=%0d: got %b want %b", di, df, k, mid_tick, (k % OS == OS / 2));
      end
      if (bit_tick === 1'b1) begin
        if (first_bit < 0) first_bit = t;
        else if (bit_gap < 0) bit_gap = t - first_bit;
      end
    end
    elapsed = t - start;
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; div_int_i = '0; div_frac_i = '0; div_load = 1'b0; resync = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000) begin
      bad++; $display("FAIL reset_ticks: got %b want 000", {os_tick, bit_tick, mid_tick});
    end
    total++;
    if (os_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_os_cnt: got %0d want 0", os_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_defaults();
    int e, g;
    test_run(27, 2, 16, 1'b0, e, g);
    total++;
    if (e !== 434) begin
      bad++; $display("FAIL default_16_ticks: got %0d clocks want 434", e);
    end
  endtask

  task automatic test_div4_frac0();
    int e, g;
    test_run(4, 0, 16, 1'b1, e, g);
    total++;
    if (e !== 64) begin
      bad++; $display("FAIL div4_bit_time: got %0d clocks want 64", e);
    end
  endtask

  task automatic test_div4_frac8();
    int e, g;
    test_run(4, 8, 32, 1'b1, e, g);
    total++;
    if (g !== 72) begin
      bad++; $display("FAIL frac8_bit_spacing: got %0d want 72", g);
    end
  endtask

  task automatic test_div_load();
    int s, t, t1, t2, t3;
    int expt[$];
    load_div(4, 0);
    @(negedge clk);
    en = 1'b1; s = cyc;
    wait_tick(t1);
    total++;
    if (t1 !== s + 4) begin
      bad++; $display("FAIL load_first: got %0d want %0d", t1 - s, 4);
    end
    repeat (2) @(negedge clk);
    load_div(10, 0);
    wait_tick(t);
    wait_tick(t2);
    total++;
    if (t !== t1 + 4 || t2 !== t1 + 14) begin
      bad++; $display("FAIL load_midperiod: got periods %0d,%0d want 4,10", t - t1, t2 - t);
    end
    @(negedge clk);
    load_div(1, 0);
    expt = '{t2 + 10, t2 + 12, t2 + 14};
    foreach (expt[i]) begin
      wait_tick(t3);
      total++;
      if (t3 !== expt[i]) begin
        bad++; $display("FAIL load_clamp idx=%0d: got %0d want %0d", i, t3 - t2, expt[i] - t2);
      end
    end
    load_div(6, 0);
    wait_tick(t);
    total++;
    if (t !== t3 + 6) begin
      bad++; $display("FAIL load_at_start: got period %0d want 6", t - t3);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_resync();
    int s, t;
    load_div(4, 0);
    @(negedge clk);
    en = 1'b1;
    t = 0;
    for (int k = 0; k < 15; k++) wait_tick(t);
    total++;
    if (os_cnt !== 4'd15) begin
      bad++; $display("FAIL resync_pre_cnt: got %0d want 15", os_cnt);
    end
    repeat (3) @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    total++;
    if ({os_tick, bit_tick} !== 2'b00 || os_cnt !== 4'd0) begin
      bad++; $display("FAIL resync_suppress: got tick=%b bit=%b cnt=%0d want 0 0 0", os_tick, bit_tick, os_cnt);
    end
    s = cyc;
    for (int k = 1; k <= 16; k++) begin
      wait_tick(t);
      total++;
      if (t !== s + 4 * k || bit_tick !== (k == 16)) begin
        bad++; $display("FAIL resync_after k=%0d: got cycle %0d bit=%b want %0d bit=%b", k, t - s, bit_tick, 4 * k, (k == 16));
      end
    end
    resync = 1'b1;
    load_div(7, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (os_tick !== 1'b0 || os_cnt !== 4'd0) begin
        bad++; $display("FAIL resync_held i=%0d: got tick=%b cnt=%0d want 0 0", i, os_tick, os_cnt);
      end
    end
    resync = 1'b0; s = cyc;
    wait_tick(t);
    total++;
    if (t !== s + 7) begin
      bad++; $display("FAIL resync_with_load: got %0d want 7", t - s);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midbit();
    int s, t;
    load_div(4, 0);
    @(negedge clk);
    en = 1'b1;
    t = 0;
    for (int k = 0; k < 5; k++) wait_tick(t);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({os_tick, bit_tick, mid_tick} !== 3'b000 || os_cnt !== 4'd0) begin
      bad++; $display("FAIL async_reset: got ticks=%b cnt=%0d want 000 0", {os_tick, bit_tick, mid_tick}, os_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; s = cyc;
    wait_tick(t);
    total++;
    if (t !== s + 27 || os_cnt !== 4'd1) begin
      bad++; $display("FAIL reset_defaults: got period %0d cnt=%0d want 27 1", t - s, os_cnt);
    end
    en = 1'b0;
    load_div(5, 0);
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 3; k++) wait_tick(t);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (os_tick !== 1'b0 || os_cnt !== 4'd0) begin
          bad++; $display("FAIL en_low i=%0d: got tick=%b cnt=%0d want 0 0", i, os_tick, os_cnt);
        end
      end
    end
    en = 1'b1; s = cyc;
    wait_tick(t);
    total++;
    if (t !== s + 5 || os_cnt !== 4'd1) begin
      bad++; $display("FAIL reenable: got period %0d cnt=%0d want 5 1", t - s, os_cnt);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int di, df, e, g;
    for (int i = 0; i < 4; i++) begin
      di = int'($urandom_range(0, 9));
      df = int'($urandom_range(0, 15));
      test_run(di, df, 20, 1'b1, e, g);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_div4_frac0();
    test_div4_frac8();
    test_div_load();
    test_resync();
    test_reset_midbit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
